frame_scan: RTL

FRAME_SCAN -- requirements
Module: frame_scan

---
 rtl/frame_scan.sv | 133 +++++++++++++
 1 files changed

// File: rtl/frame_scan.sv
// Frame-buffer scan-out: walks the buffer in raster order and emits registered
// pixels with active-low hsync/vsync, pixel-valid and end-of-frame strobes.
module frame_scan #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int H_ACTIVE   = 4,
    parameter int V_ACTIVE   = 2,
    parameter int H_BLANK    = 2,
    parameter int V_BLANK    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_rdy,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_done
);

    localparam int VB_LEN = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int H_MAX  = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
    localparam int HW     = $clog2(H_MAX + 1);
    localparam int VW     = $clog2(V_ACTIVE + 1);
    localparam int BW     = $clog2(VB_LEN + 1);

    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_BLK_LAST = HW'(H_BLANK - 1);
    localparam logic [VW-1:0] V_ACT_N    = VW'(V_ACTIVE);
    localparam logic [BW-1:0] VB_LAST    = BW'(VB_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         h_cnt, h_d;
    logic [VW-1:0]         v_cnt, v_d;
    logic [BW-1:0]         vb_cnt, vb_d;
    logic [ADDR_WIDTH-1:0] addr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            vb_cnt  <= '0;
            rd_addr <= '0;
        end else begin
            state_q <= state_d;
            h_cnt   <= h_d;
            v_cnt   <= v_d;
            vb_cnt  <= vb_d;
            rd_addr <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_cnt;
        v_d     = v_cnt;
        vb_d    = vb_cnt;
        addr_d  = rd_addr;
        case (state_q)
            IDLE: begin
                if (!frame_rdy) begin
                    state_d = ACTIVE;
                    h_d     = '0;
                    v_d     = '0;
                    addr_d  = '0;
                end
            end
            ACTIVE: begin
                addr_d = rd_addr + ADDR_WIDTH'(1);
                if (h_cnt == H_ACT_LAST) begin
                    h_d     = '0;
                    state_d = HBLANK;
                end else begin
                    h_d = h_cnt + HW'(1);
                end
            end
            HBLANK: begin
                if (h_cnt == H_BLK_LAST) begin
                    h_d     = '0;
                    v_d     = v_cnt + VW'(1);
                    state_d = (v_d < V_ACT_N) ? ACTIVE : VBLANK;
                end else begin
                    h_d = h_cnt + HW'(1);
                end
            end
            VBLANK: begin
                // frame_rdy is only consulted here and in IDLE, so a frame always completes
                if (vb_cnt == VB_LAST) begin
                    vb_d    = '0;
                    v_d     = '0;
                    addr_d  = '0;
                    state_d = frame_rdy ? IDLE : ACTIVE;
                end else begin
                    vb_d = vb_cnt + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en      = 1'b1;
        hsync      = 1'b1;
        vsync      = 1'b1;
        frame_done = 1'b1;
        case (state_q)
            ACTIVE:  rd_en = 1'b0;
            HBLANK:  hsync = 1'b0;
            VBLANK: begin
                vsync      = 1'b0;
                frame_done = (vb_cnt != VB_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid <= 1'b1;
            pix_data  <= '0;
        end else begin
            pix_valid <= rd_en;
            pix_data  <= rd_en ? '0 : rd_data;
        end
    end

endmodule
